// File: rtl/serial_tdm_decoder.sv
// Serial TDM frame decoder: recovers CHANNELS slots of SLOT_BITS each from a
// framed serial stream in left-justified or I2S timing, and queues them as
// OUT_BITS words in a small FIFO with a valid/ready handshake.
module serial_tdm_decoder #(
    parameter int CHANNELS   = 8,
    parameter int SLOT_BITS  = 32,
    parameter int OUT_BITS   = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                                sclk,
    input  logic                                                reset_n,
    input  logic                                                is_i2s,
    input  logic                                                fs_polarity,
    input  logic                                                fsync,
    input  logic                                                sdin,
    input  logic                                                o_ready,
    output logic                                                o_valid,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]  o_channel,
    output logic                                                o_last,
    output logic [OUT_BITS-1:0]                                 o_audio,
    output logic                                                is_error,
    output logic                                                overflow
);

    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BIT_W  = $clog2(SLOT_BITS);
    localparam int SLOT_W = $clog2(CHANNELS + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int E_W    = 1 + CH_W + OUT_BITS;

    typedef enum logic {ST_HUNT, ST_RECEIVE} state_t;

    // MSB-align a slot into the output width: zero-pad narrow slots,
    // truncate LSBs of wide slots.
    function automatic logic [OUT_BITS-1:0] align_word(input logic [SLOT_BITS-1:0] w);
        logic [SLOT_BITS+OUT_BITS-1:0] ext;
        ext = {w, {OUT_BITS{1'b0}}};
        return ext[SLOT_BITS+OUT_BITS-1 -: OUT_BITS];
    endfunction

    state_t                state_q, state_d;
    logic                  fs_prev_q, edge_dly_q;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic                  err_q, err_d;
    logic [SLOT_BITS-2:0]  shift_q, shift_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [E_W-1:0]        pend_q, pend_d;
    logic [E_W-1:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ovf_q, ovf_d;

    logic                  fs_now, frame_edge, frame_start;
    logic [SLOT_BITS-1:0]  word_now;
    logic                  push, pop, full;
    logic [E_W-1:0]        head;

    // Frame edge detection; I2S delays the frame start by one sample.
    always_comb begin
        fs_now      = fsync ^ fs_polarity;
        frame_edge  = fs_now & ~fs_prev_q;
        frame_start = is_i2s ? edge_dly_q : frame_edge;
        word_now    = {shift_q, sdin};
    end

    // Bit/slot counting, frame-length checking and slot capture.
    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        slot_d     = slot_q;
        err_d      = err_q;
        shift_d    = shift_q;
        pend_vld_d = 1'b0;
        pend_d     = pend_q;
        if (frame_start) begin
            // A frame ends correctly only when exactly CHANNELS slots arrived.
            if (state_q == ST_RECEIVE) begin
                if (slot_q == SLOT_W'(CHANNELS) && bit_q == '0) begin
                    err_d = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
            state_d = ST_RECEIVE;
            shift_d = word_now[SLOT_BITS-2:0];
            bit_d   = BIT_W'(1);
            slot_d  = '0;
        end else if (state_q == ST_RECEIVE) begin
            if (slot_q == SLOT_W'(CHANNELS)) begin
                // Frame ran past its length: drop bits until the next start.
                err_d   = 1'b1;
                state_d = ST_HUNT;
                bit_d   = '0;
                slot_d  = '0;
            end else begin
                shift_d = word_now[SLOT_BITS-2:0];
                if (bit_q == BIT_W'(SLOT_BITS - 1)) begin
                    pend_vld_d = 1'b1;
                    pend_d     = {(slot_q == SLOT_W'(CHANNELS - 1)), CH_W'(slot_q),
                                  align_word(word_now)};
                    bit_d      = '0;
                    slot_d     = slot_q + 1'b1;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
        end
    end

    // Output FIFO pointer/count update and overflow detection.
    always_comb begin
        full     = (count_q == CNT_W'(FIFO_DEPTH));
        pop      = o_valid & o_ready;
        push     = pend_vld_q & (~full | pop);
        ovf_d    = pend_vld_q & full & ~pop;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_HUNT;
            fs_prev_q  <= 1'b1;
            edge_dly_q <= 1'b0;
            bit_q      <= '0;
            slot_q     <= '0;
            err_q      <= 1'b0;
            pend_vld_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fs_prev_q  <= fs_now;
            edge_dly_q <= frame_edge;
            bit_q      <= bit_d;
            slot_q     <= slot_d;
            err_q      <= err_d;
            pend_vld_q <= pend_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    // Datapath registers: shift register, pending word and FIFO storage.
    always_ff @(posedge sclk) begin
        shift_q <= shift_d;
        pend_q  <= pend_d;
        if (push) begin
            mem_q[wr_ptr_q] <= pend_q;
        end
    end

    // Head-of-FIFO outputs, forced to zero whenever the FIFO is empty.
    always_comb begin
        head      = mem_q[rd_ptr_q];
        o_valid   = (count_q != '0);
        o_last    = o_valid & head[E_W-1];
        o_channel = o_valid ? head[OUT_BITS +: CH_W] : '0;
        o_audio   = o_valid ? head[OUT_BITS-1:0] : '0;
        is_error  = err_q;
        overflow  = ovf_q;
    end

endmodule
